controller_input_fifo: RTL and testbench
========================================

// Module: controller_input_fifo
// PURPOSE
//  Conditions the raw 5-bit game controller lines before they reach the CPU's controller_in path.
//  - Synchronises each line into clk.
//  - Debounces each bit independently.
//  - Detects press edges and queues them as event words in a small FIFO.
//  - The CPU drains the FIFO through a memory-mapped read strobe; it also gets the live debounced state.
// PARAMETERS
//  DEBOUNCE_CYCLES  250_000  consecutive stable cycles needed before a bit's debounced value changes (5 ms @ 50 MHz)
//  CNT_WIDTH        18       width of each per-bit debounce counter; must hold DEBOUNCE_CYCLES-1
//  FIFO_DEPTH       8        event FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1   system clock (50 MHz board clock)
//  reset        in   1   asynchronous, active-low reset
//  ctrl_raw     in   5   raw controller lines, asynchronous, active-high = button pressed
//  rd_en        in   1   CPU read strobe; pops one event when evt_valid=1
//  held         out  5   debounced button state
//  evt_valid    out  1   FIFO non-empty; evt_data is meaningful
//  evt_data     out  16  head event: [4:0] press mask, [9:5] release mask, [15:10] 0
//  evt_count    out  4   number of queued events, 0..FIFO_DEPTH
//  overflow     out  1   sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (reset=0, async): all of the following clear immediately and stay cleared while reset is low:
//   - sync flops, debounce counters, held, FIFO pointers, evt_count, overflow
//   - all outputs read 0; evt_data reads 0 when the FIFO is empty
//  Sync:
//   - 2-flop synchroniser per bit; s = second stage
//   - raw to s latency is 2 clk
//  Debounce, per bit i:
//   - if s[i]==held[i]: cnt[i] <= 0
//   - else if cnt[i]==DEBOUNCE_CYCLES-1: held[i] <= s[i], cnt[i] <= 0
//   - else: cnt[i] <= cnt[i]+1
//   - net effect: a change must persist DEBOUNCE_CYCLES cycles; any glitch restarts the count
//  Edges:
//   - nxt = next value of held
//   - press = nxt & ~held; release = ~nxt & held
//   - edges on several bits in the same cycle form ONE event word, not several
//  Push:
//   - push when the event word's masks are non-zero (which masks count depends on RELEASE_EVT_EN)
//   - the event is written in the same cycle held updates
//   - visible on evt_data the next cycle (first-word-fall-through, registered pointers)
//  Pop:
//   - rd_en && evt_valid advances the read pointer
//   - rd_en while empty is ignored; no underflow, pointers unchanged
//  Full:
//   - push while full with no pop: the new event is dropped and overflow <= 1
//   - overflow clears only on reset, or on the first pop that leaves evt_count==0
//  Simultaneous push and pop:
//   - both take effect; evt_count is unchanged
//   - when full, this is NOT an overflow
//  Pointers:
//   - log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH
//   - full/empty derived from evt_count
//  Reset mid-debounce discards partial counts; reset with queued events discards them.
// CONFIGURATION
//  RELEASE_EVT_EN defined:
//   - release edges are recorded in evt_data[9:5]
//   - a release-only edge pushes an event
//  RELEASE_EVT_EN undefined:
//   - evt_data[9:5] is forced to 0
//   - only non-zero press masks push; release-only edges change held but queue nothing
//   - release edge logic is not synthesised
// TESTING (bench uses DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
//  1. reset=0 with ctrl_raw=5'h1F
//     -> held=0, evt_valid=0, evt_count=0, overflow=0, evt_data=0.
//  2. After reset release, ctrl_raw 0->5'h01 held steady
//     -> held=5'h01 exactly 2+4 clk after the change; next clk evt_valid=1, evt_data=16'h0001.
//  3. ctrl_raw[2] pulses high for 3 clk, then low
//     -> held unchanged, evt_count stays 0.
//  4. Five press events, no rd_en
//     -> evt_count=4, overflow=1, head event = first press.
//     Then four rd_en pulses -> data in order, evt_count=0, overflow=0; a fifth rd_en -> no change.
//  5. FIFO full, and rd_en coincides with a new press
//     -> evt_count stays 4, overflow stays 0, the new event lands at the tail.
//  6. Release of button 0 from held=5'h01
//     -> with RELEASE_EVT_EN: event 16'h0020.
//     -> without RELEASE_EVT_EN: held=0 and evt_count unchanged.

Source files
------------

// File: rtl/controller_input_fifo.sv
// controller_input_fifo: conditions the raw 5-bit controller lines for the CPU.
// Each line is synchronised and debounced on its own. Press edges (and,
// optionally, release edges) are packed into one event word per cycle and
// queued in a first-word-fall-through FIFO that the CPU drains with rd_en.
// Optional feature macro: RELEASE_EVT_EN (records release edges in evt_data[9:5]).
module controller_input_fifo #(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int CNT_WIDTH       = 18,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ctrl_raw,
    input  logic        rd_en,
    output logic [4:0]  held,
    output logic        evt_valid,
    output logic [15:0] evt_data,
    output logic [3:0]  evt_count,
    output logic        overflow
);

    localparam int                   PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]           DEPTH_CNT = 4'(FIFO_DEPTH);

    logic [4:0]           sync1_q, sync2_q;
    logic [CNT_WIDTH-1:0] cnt_q [5];
    logic [CNT_WIDTH-1:0] cnt_d [5];
    logic [4:0]           held_q, held_d;

    logic [4:0]           press_mask, release_mask;
    logic                 push, pop, full, empty, wr_en;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]           count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [9:0]           mem_q [FIFO_DEPTH];

    // Two-flop synchroniser per line; sync2_q is the clean sampled value.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ctrl_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: a differing sample must persist DEBOUNCE_CYCLES cycles; any agreement restarts the count.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != held_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    held_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Debounce counters and debounced state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            held_q <= held_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Edge masks come from the transition held is about to make, so the event is written with the update.
    assign press_mask = held_d & ~held_q;
`ifdef RELEASE_EVT_EN
    assign release_mask = ~held_d & held_q;
    assign push         = |{release_mask, press_mask};
`else
    assign release_mask = '0;
    assign push         = |press_mask;
`endif

    assign empty = (count_q == 4'd0);
    assign full  = (count_q == DEPTH_CNT);
    assign pop   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);

    // FIFO bookkeeping: pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end else if (pop && !wr_en && count_q == 4'd1) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Event storage; when full with a pop, the write reuses the slot being read out this cycle.
    // NOTE: storage is not reset; the occupancy count gates evt_data so stale words are never seen.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {release_mask, press_mask};
    end

    assign held      = held_q;
    assign evt_valid = !empty;
    assign evt_data  = empty ? 16'h0000 : {6'b0, mem_q[rd_ptr_q]};
    assign evt_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_controller_input_fifo.sv
// Directed self-checking bench for controller_input_fifo (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_controller_input_fifo;

    logic        clk;
    logic        reset;
    logic [4:0]  ctrl_raw;
    logic        rd_en;
    logic [4:0]  held;
    logic        evt_valid;
    logic [15:0] evt_data;
    logic [3:0]  evt_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    controller_input_fifo #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ctrl_raw (ctrl_raw),
        .rd_en    (rd_en),
        .held     (held),
        .evt_valid(evt_valid),
        .evt_data (evt_data),
        .evt_count(evt_count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        ctrl_raw = 5'h1F;
        rd_en    = 1'b0;
        cycles(3);
        checks++; if (held !== 5'h00) begin failures++; $display("FAIL reset_held got=%h exp=%h", held, 5'h00); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
        checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", evt_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (evt_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", evt_data); end
        ctrl_raw = 5'h00;
        reset    = 1'b1;
        cycles(8);
    endtask

    task automatic test_press_latency();
        ctrl_raw = 5'h01;
        cycles(5);
        checks++; if (held !== 5'h00) begin failures++; $display("FAIL latency_early_held got=%h exp=%h", held, 5'h00); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL latency_early_valid got=%b exp=0", evt_valid); end
        cycles(1);
        checks++; if (held !== 5'h01) begin failures++; $display("FAIL latency_held got=%h exp=%h", held, 5'h01); end
        cycles(1);
        checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b exp=1", evt_valid); end
        checks++; if (evt_data !== 16'h0001) begin failures++; $display("FAIL latency_data got=%h exp=0001", evt_data); end
        checks++; if (evt_count !== 4'd1) begin failures++; $display("FAIL latency_count got=%0d exp=1", evt_count); end
        pulse_rd();
        checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL latency_pop_count got=%0d exp=0", evt_count); end
        checks++; if (evt_data !== 16'h0000) begin failures++; $display("FAIL latency_pop_data got=%h exp=0000", evt_data); end
    endtask

    task automatic test_glitch();
        ctrl_raw = 5'h05;
        cycles(3);
        ctrl_raw = 5'h01;
        cycles(10);
        checks++; if (held !== 5'h01) begin failures++; $display("FAIL glitch_held got=%h exp=%h", held, 5'h01); end
        checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL glitch_count got=%0d exp=0", evt_count); end
    endtask

    task automatic test_overflow();
        logic [4:0]  pats [5] = '{5'h01, 5'h03, 5'h07, 5'h0F, 5'h1F};
        logic [15:0] exp_d;
        ctrl_raw = 5'h00;
        cycles(8);
`ifdef RELEASE_EVT_EN
        pulse_rd();
`endif
        for (int p = 0; p < 5; p++) begin
            ctrl_raw = pats[p];
            cycles(8);
        end
        checks++; if (held !== 5'h1F) begin failures++; $display("FAIL ovf_held got=%h exp=%h", held, 5'h1F); end
        checks++; if (evt_count !== 4'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", evt_count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int k = 0; k < 4; k++) begin
            exp_d = 16'h0001 << k;
            checks++; if (evt_data !== exp_d) begin failures++; $display("FAIL ovf_drain_data[%0d] got=%h exp=%h", k, evt_data, exp_d); end
            checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_drain_flag[%0d] got=%b exp=1", k, overflow); end
            pulse_rd();
        end
        checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL ovf_empty_count got=%0d exp=0", evt_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty_valid got=%b exp=0", evt_valid); end
        pulse_rd();
        checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL underflow_count got=%0d exp=0", evt_count); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL underflow_valid got=%b exp=0", evt_valid); end
        checks++; if (evt_data !== 16'h0000) begin failures++; $display("FAIL underflow_data got=%h exp=0000", evt_data); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  pats [4] = '{5'h01, 5'h03, 5'h07, 5'h0F};
        logic [15:0] exp_d;
        ctrl_raw = 5'h00;
        cycles(8);
`ifdef RELEASE_EVT_EN
        pulse_rd();
`endif
        for (int p = 0; p < 4; p++) begin
            ctrl_raw = pats[p];
            cycles(8);
        end
        checks++; if (evt_count !== 4'd4) begin failures++; $display("FAIL b2b_full_count got=%0d exp=4", evt_count); end
        ctrl_raw = 5'h1F;
        cycles(5);
        checks++; if (held !== 5'h0F) begin failures++; $display("FAIL b2b_pre_held got=%h exp=%h", held, 5'h0F); end
        pulse_rd();
        checks++; if (held !== 5'h1F) begin failures++; $display("FAIL b2b_held got=%h exp=%h", held, 5'h1F); end
        checks++; if (evt_count !== 4'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", evt_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
        for (int k = 0; k < 4; k++) begin
            exp_d = 16'h0002 << k;
            checks++; if (evt_data !== exp_d) begin failures++; $display("FAIL b2b_drain_data[%0d] got=%h exp=%h", k, evt_data, exp_d); end
            pulse_rd();
        end
        checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL b2b_empty_count got=%0d exp=0", evt_count); end
    endtask

    task automatic test_release();
        ctrl_raw = 5'h01;
        cycles(8);
`ifdef RELEASE_EVT_EN
        checks++; if (evt_data !== 16'h03C0) begin failures++; $display("FAIL rel_multi_data got=%h exp=03c0", evt_data); end
        pulse_rd();
`endif
        ctrl_raw = 5'h00;
        cycles(8);
        checks++; if (held !== 5'h00) begin failures++; $display("FAIL rel_held got=%h exp=%h", held, 5'h00); end
`ifdef RELEASE_EVT_EN
        checks++; if (evt_count !== 4'd1) begin failures++; $display("FAIL rel_count got=%0d exp=1", evt_count); end
        checks++; if (evt_data !== 16'h0020) begin failures++; $display("FAIL rel_data got=%h exp=0020", evt_data); end
        pulse_rd();
`else
        checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL rel_count got=%0d exp=0", evt_count); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rel_valid got=%b exp=0", evt_valid); end
`endif
    endtask

    task automatic test_reset_flush();
        ctrl_raw = 5'h01;
        cycles(8);
        checks++; if (evt_count !== 4'd1) begin failures++; $display("FAIL flush_pre_count got=%0d exp=1", evt_count); end
        reset = 1'b0;
        #1;
        checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", evt_count); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", evt_valid); end
        checks++; if (held !== 5'h00) begin failures++; $display("FAIL flush_held got=%h exp=%h", held, 5'h00); end
        checks++; if (evt_data !== 16'h0000) begin failures++; $display("FAIL flush_data got=%h exp=0000", evt_data); end
        cycles(1);
        ctrl_raw = 5'h00;
        reset    = 1'b1;
        cycles(4);
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_release();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
